// File: rtl/mp4_sram_pkg.sv
// Shared constants and clear-sequencer state type for the mp4 1RW/1R SRAM model.
package mp4_sram_pkg;

    localparam int DEFAULT_DATA_WIDTH = 128;
    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int DEFAULT_BYTE_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 2 ** DEFAULT_ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    function automatic int lane_count(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/mp4_sram_wmask_merge.sv
// Combinational per-lane merge of the stored word with new write data under a lane mask.
module mp4_sram_wmask_merge
    import mp4_sram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BYTE_WIDTH = DEFAULT_BYTE_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]            old_word,
    input  logic [DATA_WIDTH-1:0]            new_word,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] mask,
    output logic [DATA_WIDTH-1:0]            merged
);

    localparam int NUM_WMASKS = lane_count(DATA_WIDTH, BYTE_WIDTH);

    // Select each lane from new data when its mask bit is set
    always_comb begin
        merged = old_word;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (mask[i]) begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] = old_word[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

endmodule

// File: rtl/mp4_sram_1rw1r.sv
// One read/write plus one read-only port SRAM: inputs captured on posedge, array and dout on the
// following negedge. Define SRAM_INIT_CLEAR_EN to zero the whole array after every reset release.
module mp4_sram_1rw1r
    import mp4_sram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int BYTE_WIDTH = DEFAULT_BYTE_WIDTH,
    parameter int T_HOLD     = 1
) (
    input  logic                             clk0,
    input  logic                             rst_n,
    input  logic                             csb0,
    input  logic                             web0,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]            addr0,
    input  logic [DATA_WIDTH-1:0]            din0,
    output logic [DATA_WIDTH-1:0]            dout0,
    input  logic                             csb1,
    input  logic [ADDR_WIDTH-1:0]            addr1,
    output logic [DATA_WIDTH-1:0]            dout1,
    output logic                             ready
);

    localparam int NUM_WMASKS = lane_count(DATA_WIDTH, BYTE_WIDTH);
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic                  csb0_r;
    logic                  web0_r;
    logic [NUM_WMASKS-1:0] wmask0_r;
    logic [ADDR_WIDTH-1:0] addr0_r;
    logic [DATA_WIDTH-1:0] din0_r;
    logic                  csb1_r;
    logic [ADDR_WIDTH-1:0] addr1_r;
    logic                  rst_seen_r;
    logic                  ready_r;
    logic [DATA_WIDTH-1:0] dout0_r;
    logic [DATA_WIDTH-1:0] dout1_r;

    logic [DATA_WIDTH-1:0] old_word_s;
    logic [DATA_WIDTH-1:0] merged_s;
    logic                  wr_hit_s;

    // Access capture; chip selects are forced inactive while not ready so the access is dropped
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            csb0_r     <= 1'b1;
            web0_r     <= 1'b1;
            wmask0_r   <= '0;
            addr0_r    <= '0;
            din0_r     <= '0;
            csb1_r     <= 1'b1;
            addr1_r    <= '0;
            rst_seen_r <= 1'b1;
        end else begin
            csb0_r     <= csb0 | ~ready_r;
            web0_r     <= web0;
            wmask0_r   <= wmask0;
            addr0_r    <= addr0;
            din0_r     <= din0;
            csb1_r     <= csb1 | ~ready_r;
            addr1_r    <= addr1;
            rst_seen_r <= 1'b0;
        end
    end

`ifdef SRAM_INIT_CLEAR_EN
    clr_state_e            state_r;
    clr_state_e            state_nxt_s;
    logic [ADDR_WIDTH-1:0] clr_addr_r;
    logic [ADDR_WIDTH-1:0] clr_addr_nxt_s;
    logic                  clr_go_s;
    logic                  clr_req_r;
    logic [ADDR_WIDTH-1:0] clr_wr_addr_r;

    // Clear sequencer state and the clear write handed to the negedge array update
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            state_r       <= CLEAR;
            clr_addr_r    <= '0;
            clr_req_r     <= 1'b0;
            clr_wr_addr_r <= '0;
            ready_r       <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            clr_addr_r    <= clr_addr_nxt_s;
            clr_req_r     <= clr_go_s;
            clr_wr_addr_r <= clr_addr_r;
            ready_r       <= (state_nxt_s == READY);
        end
    end

    // Walk every address once, then hand the array over to the ports
    always_comb begin
        state_nxt_s    = state_r;
        clr_addr_nxt_s = clr_addr_r;
        clr_go_s       = 1'b0;
        case (state_r)
            CLEAR: begin
                clr_go_s       = 1'b1;
                clr_addr_nxt_s = clr_addr_r + ADDR_WIDTH'(1);
                if (clr_addr_r == {ADDR_WIDTH{1'b1}}) begin
                    state_nxt_s = READY;
                end else begin
                    state_nxt_s = CLEAR;
                end
            end
            READY: begin
                state_nxt_s = READY;
            end
            default: begin
                state_nxt_s = CLEAR;
            end
        endcase
    end
`else
    // Array is usable from the first cycle after reset release
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= 1'b1;
        end
    end
`endif

    assign old_word_s = mem_r[addr0_r];
    assign wr_hit_s   = !csb0_r && !web0_r && (addr1_r == addr0_r);

    mp4_sram_wmask_merge #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_merge (
        .old_word (old_word_s),
        .new_word (din0_r),
        .mask     (wmask0_r),
        .merged   (merged_s)
    );

    // Array write and read-out half a cycle after capture; port 1 sees a same-address write first
    always_ff @(negedge clk0) begin
        if (rst_seen_r) begin
            dout0_r <= '0;
            dout1_r <= '0;
        end else begin
            if (!csb0_r) begin
                if (!web0_r) begin
                    mem_r[addr0_r] <= merged_s;
                    dout0_r        <= merged_s;
                end else begin
                    dout0_r        <= old_word_s;
                end
            end
            if (!csb1_r) begin
                if (wr_hit_s) begin
                    dout1_r <= merged_s;
                end else begin
                    dout1_r <= mem_r[addr1_r];
                end
            end
`ifdef SRAM_INIT_CLEAR_EN
            if (clr_req_r) begin
                mem_r[clr_wr_addr_r] <= '0;
            end
`endif
        end
    end

    // T_HOLD only shapes output hold timing in behavioural models; cycle behaviour ignores it
    if (T_HOLD >= 0) begin : g_dout
        assign dout0 = dout0_r;
        assign dout1 = dout1_r;
    end else begin : g_dout_nohold
        assign dout0 = dout0_r;
        assign dout1 = dout1_r;
    end

    assign ready = ready_r;

endmodule

// File: tb/tb_mp4_sram_1rw1r.sv
// Randomized scoreboard bench for mp4_sram_1rw1r against an array-level reference model.
module tb_mp4_sram_1rw1r;

    localparam int DW    = 128;
    localparam int AW    = 4;
    localparam int BW    = 8;
    localparam int NM    = DW / BW;
    localparam int DEPTH = 16;
`ifdef SRAM_INIT_CLEAR_EN
    localparam int CLR_LEN = DEPTH;
`else
    localparam int CLR_LEN = 0;
`endif

    logic          clk0 = 1'b0;
    logic          rst_n;
    logic          csb0;
    logic          web0;
    logic [NM-1:0] wmask0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0;
    logic          csb1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] dout1;
    logic          ready;

    always #5 clk0 = ~clk0;

    mp4_sram_1rw1r #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BYTE_WIDTH (BW),
        .T_HOLD     (1)
    ) dut (
        .clk0   (clk0),
        .rst_n  (rst_n),
        .csb0   (csb0),
        .web0   (web0),
        .wmask0 (wmask0),
        .addr0  (addr0),
        .din0   (din0),
        .dout0  (dout0),
        .csb1   (csb1),
        .addr1  (addr1),
        .dout1  (dout1),
        .ready  (ready)
    );

    typedef struct {
        int          due;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        bit          k0;
        bit          k1;
    } dexp_t;

    typedef struct {
        int due;
        bit r;
    } rexp_t;

    dexp_t dq[$];
    rexp_t rq[$];

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    // reference model: array contents, which words hold defined data, held outputs
    logic [DW-1:0] mdl   [DEPTH];
    bit            known [DEPTH];
    logic [DW-1:0] m_d0  = '0;
    logic [DW-1:0] m_d1  = '0;
    bit            m_k0  = 1'b0;
    bit            m_k1  = 1'b0;
    bit            m_rdy = 1'b0;
    int            m_clr = 0;

    always @(posedge clk0) cyc <= cyc + 1;

    function automatic logic [DW-1:0] lane_write(input logic [DW-1:0] old_w,
                                                 input logic [DW-1:0] new_w,
                                                 input logic [NM-1:0] m);
        logic [DW-1:0] res;
        res = old_w;
        for (int i = 0; i < NM; i++) begin
            if (m[i]) res[i*BW +: BW] = new_w[i*BW +: BW];
        end
        return res;
    endfunction

    task automatic op(input bit rst, input bit c0, input bit w0, input logic [NM-1:0] m,
                      input int a0, input logic [DW-1:0] d, input bit c1, input int a1);
        dexp_t de;
        rexp_t re;
        @(posedge clk0);
        #1;
        rst_n  = ~rst;
        csb0   = c0;
        web0   = w0;
        wmask0 = m;
        addr0  = AW'(a0);
        din0   = d;
        csb1   = c1;
        addr1  = AW'(a1);
        if (rst) begin
            m_d0  = '0;
            m_d1  = '0;
            m_k0  = 1'b1;
            m_k1  = 1'b1;
            m_rdy = 1'b0;
            m_clr = CLR_LEN;
        end else begin
            if (m_rdy) begin
                if (!c0) begin
                    if (!w0) begin
                        mdl[a0]   = lane_write(mdl[a0], d, m);
                        known[a0] = known[a0] || (m == {NM{1'b1}});
                    end
                    m_d0 = mdl[a0];
                    m_k0 = known[a0];
                end
                if (!c1) begin
                    m_d1 = mdl[a1];
                    m_k1 = known[a1];
                end
            end
            if (m_clr > 0) begin
                mdl[CLR_LEN - m_clr]   = '0;
                known[CLR_LEN - m_clr] = 1'b1;
                m_clr--;
            end
            m_rdy = (m_clr == 0);
        end
        de = '{cyc + 2, m_d0, m_d1, m_k0, m_k1};
        dq.push_back(de);
        re = '{cyc + 1, m_rdy};
        rq.push_back(re);
    endtask

    task automatic idle();
        op(1'b0, 1'b1, 1'b1, '0, 0, '0, 1'b1, 0);
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [NM-1:0] m);
        op(1'b0, 1'b0, 1'b0, m, a, d, 1'b1, 0);
    endtask

    // monitor: compares outputs against queued expectations once they fall due
    initial begin
        dexp_t de;
        rexp_t re;
        forever begin
            @(posedge clk0);
            #2;
            while (rq.size() > 0 && rq[0].due <= cyc) begin
                re = rq.pop_front();
                n_checks++;
                if (re.due != cyc) begin
                    n_fail++;
                    $display("FAIL ready_stale: due %0d checked at %0d", re.due, cyc);
                end else if (ready !== re.r) begin
                    n_fail++;
                    $display("FAIL ready cyc %0d: got %b expected %b", cyc, ready, re.r);
                end
            end
            while (dq.size() > 0 && dq[0].due <= cyc) begin
                de = dq.pop_front();
                if (de.k0) begin
                    n_checks++;
                    if (de.due != cyc || dout0 !== de.d0) begin
                        n_fail++;
                        $display("FAIL dout0 cyc %0d: got %h expected %h", cyc, dout0, de.d0);
                    end
                end
                if (de.k1) begin
                    n_checks++;
                    if (de.due != cyc || dout1 !== de.d1) begin
                        n_fail++;
                        $display("FAIL dout1 cyc %0d: got %h expected %h", cyc, dout1, de.d1);
                    end
                end
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        csb0   = 1'b1;
        web0   = 1'b1;
        wmask0 = '0;
        addr0  = '0;
        din0   = '0;
        csb1   = 1'b1;
        addr1  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            known[i] = 1'b0;
            mdl[i]   = '0;
        end

        repeat (3) op(1'b1, 1'b1, 1'b1, '0, 0, '0, 1'b1, 0);

        // accesses while not ready must be dropped
        while (!m_rdy) op(1'b0, 1'b0, 1'b0, {NM{1'b1}}, 4, {16{8'hFF}}, 1'b0, 4);

        // after an optional clear every address reads back zero
        for (int a = 0; a < DEPTH; a++) op(1'b0, 1'b1, 1'b1, '0, 0, '0, 1'b0, a);

        for (int a = 0; a < DEPTH; a++)
            op(1'b0, 1'b0, 1'b0, {NM{1'b1}}, a, {$urandom(), $urandom(), $urandom(), $urandom()},
               1'b0, (a + 1) % DEPTH);

        wr(3, 128'h0F0E0D0C0B0A09080706050403020100, {NM{1'b1}});
        op(1'b0, 1'b1, 1'b1, '0, 0, '0, 1'b0, 3);

        wr(5, {16{8'hAA}}, {NM{1'b1}});
        wr(5, {16{8'h55}}, 16'h0001);

        op(1'b0, 1'b0, 1'b0, {NM{1'b1}}, 7, 128'h1234, 1'b0, 7);

        op(1'b0, 1'b0, 1'b1, '0, 3, '0, 1'b0, 5);
        repeat (3) idle();

        wr(2, {16{8'h3C}}, {NM{1'b1}});
        op(1'b1, 1'b0, 1'b0, {NM{1'b1}}, 2, {16{8'hE7}}, 1'b1, 0);
        while (!m_rdy) idle();
        op(1'b0, 1'b0, 1'b1, '0, 2, '0, 1'b0, 2);

        op(1'b0, 1'b0, 1'b0, '0, 6, {16{8'h99}}, 1'b0, 6);
        op(1'b0, 1'b0, 1'b0, {NM{1'b1}}, 15, {16{8'h5A}}, 1'b0, 0);
        op(1'b0, 1'b0, 1'b1, '0, 0, '0, 1'b0, 15);

        repeat (400) begin
            op(($urandom_range(0, 99) == 0), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
               NM'($urandom()), $urandom_range(0, DEPTH - 1),
               {$urandom(), $urandom(), $urandom(), $urandom()},
               $urandom_range(0, 3) == 0, $urandom_range(0, DEPTH - 1));
        end

        for (int g = 0; g < 10 && (dq.size() > 0 || rq.size() > 0); g++) @(posedge clk0);
        #3;
        n_checks++;
        if (dq.size() > 0 || rq.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d dout and %0d ready expectations left, expected 0",
                     dq.size(), rq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
